// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with a configurable number of register stages.
// Valid/ready on both sides; carry-out, signed overflow, zero and a passthrough tag ride with each beat.
module pipelined_prefix_adder #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);
  localparam int LOG  = $clog2(WIDTH);
  localparam int NLVL = LOG + 1;
  localparam int LPS  = (NLVL + PIPE_STAGES - 1) / PIPE_STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] s;
    logic             c0;
    logic             co;
    logic             ov;
    logic             z;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t                  st_q [PIPE_STAGES];
  beat_t                  st_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  beat_t                  prep;
  beat_t                  t;
  logic [WIDTH-1:0]       b_eff;
  logic                   c0;
  logic                   en;

  // Handshake: a beat enters on in_valid & in_ready and leaves on out_valid & out_ready.
  // One enable moves the whole pipe, so a stalled output freezes every stage, bubbles included.
  assign en       = ~vld_q[PIPE_STAGES-1] | out_ready;
  assign in_ready = en;

  always_comb begin
    b_eff     = sub ? ~b : b;
    c0        = sub ? ~cin : cin;
    prep      = '0;
    prep.h    = a ^ b_eff;
    prep.p    = a ^ b_eff;
    prep.g    = a & b_eff;
    // Carry-in folded into bit 0 so group 0 already spans the virtual position -1.
    prep.g[0] = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c0);
    prep.c0   = c0;
    prep.tag  = tag_in;
  end

  always_comb begin
    t = prep;
    for (int j = 0; j < PIPE_STAGES; j++) begin
      t = (j == 0) ? prep : st_q[(j == 0) ? 0 : j - 1];
      for (int lv = 1; lv <= NLVL; lv++) begin
        if (lv > j * LPS && lv <= (j + 1) * LPS) begin
          if (lv <= LOG) begin
            t.g = t.g | (t.p & (t.g << (1 << (lv - 1))));
            t.p = t.p & (t.p << (1 << (lv - 1)));
          end else begin
            t.s  = t.h ^ {t.g[WIDTH-2:0], t.c0};
            t.co = t.g[WIDTH-1];
            t.ov = t.g[WIDTH-1] ^ t.g[WIDTH-2];
            t.z  = ~|(t.h ^ {t.g[WIDTH-2:0], t.c0});
          end
        end
      end
      st_d[j] = t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int j = 0; j < PIPE_STAGES; j++) st_q[j] <= '0;
    end else if (en) begin
      for (int j = 0; j < PIPE_STAGES; j++) begin
        vld_q[j] <= (j == 0) ? in_valid : vld_q[(j == 0) ? 0 : j - 1];
        // Bubbles leave stage data untouched so idle stages do not toggle.
        if ((j == 0) ? in_valid : vld_q[(j == 0) ? 0 : j - 1]) st_q[j] <= st_d[j];
      end
    end
  end

  assign out_valid = vld_q[PIPE_STAGES-1];
  assign s         = st_q[PIPE_STAGES-1].s;
  assign cout      = st_q[PIPE_STAGES-1].co;
  assign ovf       = st_q[PIPE_STAGES-1].ov;
  assign zero      = st_q[PIPE_STAGES-1].z;
  assign tag_out   = st_q[PIPE_STAGES-1].tag;
endmodule
